// File: rtl/saes_pkg.sv
// Simplified-AES shared definitions.
// Provides the 4-bit S-box and its inverse, GF(2^4) multiply (x^4 + x + 1), key-schedule
// round constants, the engine state encoding and the key expansion used at key load.
package saes_pkg;

  localparam logic [7:0] RCON1 = 8'h80;
  localparam logic [7:0] RCON2 = 8'h30;

  typedef enum logic [1:0] {IDLE, R1, R2} state_t;

  typedef struct packed {
    logic [15:0] k0;
    logic [15:0] k1;
    logic [15:0] k2;
  } subkeys_t;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'h9;  4'h1: r = 4'h4;  4'h2: r = 4'hA;  4'h3: r = 4'hB;
      4'h4: r = 4'hD;  4'h5: r = 4'h1;  4'h6: r = 4'h8;  4'h7: r = 4'h5;
      4'h8: r = 4'h6;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'h3;
      4'hC: r = 4'hC;  4'hD: r = 4'hE;  4'hE: r = 4'hF;  default: r = 4'h7;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'hA;  4'h1: r = 4'h5;  4'h2: r = 4'h9;  4'h3: r = 4'hB;
      4'h4: r = 4'h1;  4'h5: r = 4'h7;  4'h6: r = 4'h8;  4'h7: r = 4'hF;
      4'h8: r = 4'h6;  4'h9: r = 4'h0;  4'hA: r = 4'h2;  4'hB: r = 4'h3;
      4'hC: r = 4'hC;  4'hD: r = 4'h4;  4'hE: r = 4'hD;  default: r = 4'hE;
    endcase
    return r;
  endfunction

  // Shift-and-add multiply, reducing by x^4 + x + 1 whenever x^3 overflows.
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = 4'h0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[3] ? ({aa[2:0], 1'b0} ^ 4'h3) : {aa[2:0], 1'b0};
    end
    return p;
  endfunction

  // SubNib(RotNib(w)) from the key schedule.
  function automatic logic [7:0] sub_rot(input logic [7:0] w);
    return {sbox(w[3:0]), sbox(w[7:4])};
  endfunction

  function automatic subkeys_t key_expand(input logic [15:0] key);
    logic [7:0] w2, w3, w4, w5;
    subkeys_t   ks;
    w2    = key[15:8] ^ RCON1 ^ sub_rot(key[7:0]);
    w3    = w2 ^ key[7:0];
    w4    = w2 ^ RCON2 ^ sub_rot(w3);
    w5    = w4 ^ w3;
    ks.k0 = key;
    ks.k1 = {w2, w3};
    ks.k2 = {w4, w5};
    return ks;
  endfunction

endpackage

// File: rtl/saes_round_datapath.sv
// One S-AES round, shared by both round states of the engine.
// Ports:
//   st      current cipher state (nibble n0 = st[15:12], column-major)
//   subkey  round key to add
//   encrypt 1 = forward round, 0 = inverse round
//   mix_en  1 = include (Inv)MixColumns (first round), 0 = final round
//   next_st resulting state
module saes_round_datapath
  import saes_pkg::*;
(
  input  logic [15:0] st,
  input  logic [15:0] subkey,
  input  logic        encrypt,
  input  logic        mix_en,
  output logic [15:0] next_st
);

  function automatic logic [15:0] nib_sub(input logic [15:0] s, input logic inv);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = inv ? inv_sbox(s[i*4 +: 4]) : sbox(s[i*4 +: 4]);
    end
    return r;
  endfunction

  // Swapping n1 and n3 rotates the bottom row; it is its own inverse.
  function automatic logic [15:0] shift_rows(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  // Column (a, b) -> (d*a ^ o*b, o*a ^ d*b): [1 4; 4 1] forward, [9 2; 2 9] inverse.
  function automatic logic [15:0] mix_cols(input logic [15:0] s, input logic [3:0] d,
                                           input logic [3:0] o);
    return {gf16_mul(d, s[15:12]) ^ gf16_mul(o, s[11:8]),
            gf16_mul(o, s[15:12]) ^ gf16_mul(d, s[11:8]),
            gf16_mul(d, s[7:4])   ^ gf16_mul(o, s[3:0]),
            gf16_mul(o, s[7:4])   ^ gf16_mul(d, s[3:0])};
  endfunction

  logic [15:0] t;

  always_comb begin
    t       = '0;
    next_st = '0;
    if (encrypt) begin
      t       = shift_rows(nib_sub(st, 1'b0));
      if (mix_en) t = mix_cols(t, 4'h1, 4'h4);
      next_st = t ^ subkey;
    end else begin
      t       = nib_sub(shift_rows(st), 1'b1) ^ subkey;
      next_st = mix_en ? mix_cols(t, 4'h9, 4'h2) : t;
    end
  end

endmodule

// File: rtl/saes_cbc_engine.sv
// Handshaked S-AES engine, one round per clock, with cached key schedule and optional CBC.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   key_load, key               load a new key (accepted in IDLE only)
//   iv_load, iv                 load the chaining register (IDLE, no pending block)
//   in_valid/in_ready           input block handshake; in_encrypt, in_data sampled with it
//   out_valid/out_ready         result handshake; out_data held until consumed
//   busy                        a block is in flight
module saes_cbc_engine
  import saes_pkg::*;
#(
  parameter bit          CBC_EN  = 1'b1,
  parameter logic [15:0] RST_KEY = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [15:0] key,
  input  logic        iv_load,
  input  logic [15:0] iv,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_encrypt,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  state_t      state_q;
  subkeys_t    keys_q;
  logic [15:0] st_q, cin_q, chain_q, out_data_q;
  logic        enc_q, out_valid_q;

  logic        key_acc, iv_acc, in_fire;
  logic [15:0] chain_eff, subkey, round_out, result;

  assign key_acc   = (state_q == IDLE) && key_load;
  assign iv_acc    = CBC_EN && (state_q == IDLE) && iv_load && !in_valid;
  // A pending key load takes priority over a block in the same cycle.
  assign in_ready  = (state_q == IDLE) && !key_load && (!out_valid_q || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign chain_eff = CBC_EN ? chain_q : 16'h0000;

  assign subkey = (state_q == R1) ? keys_q.k1 : (enc_q ? keys_q.k2 : keys_q.k0);

  saes_round_datapath u_round (
    .st      (st_q),
    .subkey  (subkey),
    .encrypt (enc_q),
    .mix_en  (state_q == R1),
    .next_st (round_out)
  );

  // Decrypt un-chains after the last round; encrypt chained before the first.
  assign result = enc_q ? round_out : (round_out ^ chain_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      keys_q      <= key_expand(RST_KEY);
      st_q        <= '0;
      cin_q       <= '0;
      chain_q     <= '0;
      enc_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (key_acc) keys_q <= key_expand(key);
      if (iv_acc) chain_q <= iv;
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            enc_q   <= in_encrypt;
            cin_q   <= in_data;
            st_q    <= in_encrypt ? (in_data ^ chain_eff ^ keys_q.k0) : (in_data ^ keys_q.k2);
            state_q <= R1;
          end
        end
        R1: begin
          st_q    <= round_out;
          state_q <= R2;
        end
        R2: begin
          out_data_q  <= result;
          out_valid_q <= 1'b1;
          if (CBC_EN) chain_q <= enc_q ? result : cin_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_saes_cbc_engine.sv
// Directed scoreboard bench for saes_cbc_engine (CBC enabled, reset key 16'h4AF5).
module tb_saes_cbc_engine;

  logic        clk = 1'b0;
  logic        rst, key_load, iv_load, in_valid, in_encrypt, out_ready;
  logic [15:0] key, iv, in_data;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_data;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb[$];

  saes_cbc_engine #(
    .CBC_EN  (1'b1),
    .RST_KEY (16'h4AF5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_load   (key_load),
    .key        (key),
    .iv_load    (iv_load),
    .iv         (iv),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_encrypt (in_encrypt),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Output side of the scoreboard: every consumed result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_out observed=%h expected=none", out_data);
      end
      if (sb.size() > 0) begin
        logic [15:0] exp;
        exp = sb.pop_front();
        checks++;
        assert (out_data === exp) else begin
          errors++;
          $error("FAIL out_data observed=%h expected=%h", out_data, exp);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [15:0] k);
    key_load = 1'b1;
    key      = k;
    tick();
    key_load = 1'b0;
  endtask

  task automatic load_iv(input logic [15:0] v);
    iv_load = 1'b1;
    iv      = v;
    tick();
    iv_load = 1'b0;
  endtask

  task automatic send(input logic enc, input logic [15:0] d, input logic [15:0] exp,
                      input bit push);
    int n;
    n = 0;
    if (push) sb.push_back(exp);
    in_valid   = 1'b1;
    in_encrypt = enc;
    in_data    = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (in_ready === 1'b1) else begin
      errors++;
      $error("FAIL accept_timeout observed=%b expected=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d expected=0", sb.size());
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; key_load = 1'b0; iv_load = 1'b0; in_valid = 1'b0; in_encrypt = 1'b0;
    out_ready = 1'b1; key = '0; iv = '0; in_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 16'd0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_busy", busy, 16'd0);
    chk("rst_in_ready", in_ready, 16'd1);
    tick();

    // Reset key 4AF5 and zero chain already in place; also check the 2-cycle latency.
    send(1'b1, 16'hD728, 16'h24EC, 1'b1);
    @(negedge clk);
    chk("lat_busy", busy, 16'd1);
    chk("lat_valid_e0", out_valid, 16'd0);
    @(negedge clk);
    chk("lat_valid_e1", out_valid, 16'd0);
    @(negedge clk);
    chk("lat_valid_e2", out_valid, 16'd1);
    drain();

    // ECB-style decrypt then encrypt, chain cleared before each block.
    load_key(16'hA73B);
    load_iv(16'h0000);
    send(1'b0, 16'h0738, 16'h6F6B, 1'b1);
    drain();
    load_iv(16'h0000);
    send(1'b1, 16'h6F6B, 16'h0738, 1'b1);
    drain();

    // CBC encrypt two blocks, then decrypt them back.
    load_key(16'h4AF5);
    load_iv(16'h0000);
    send(1'b1, 16'hD728, 16'h24EC, 1'b1);
    drain();
    send(1'b1, 16'hF3C4, 16'h24EC, 1'b1);
    drain();
    load_iv(16'h0000);
    send(1'b0, 16'h24EC, 16'hD728, 1'b1);
    drain();
    send(1'b0, 16'h24EC, 16'hF3C4, 1'b1);
    drain();

    // Backpressure: result held, next block blocked until the consuming cycle.
    load_iv(16'h0000);
    out_ready = 1'b0;
    send(1'b1, 16'hD728, 16'h24EC, 1'b1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", out_valid, 16'd1);
    in_valid   = 1'b1;
    in_encrypt = 1'b1;
    in_data    = 16'hF3C4;
    sb.push_back(16'h24EC);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_data", out_data, 16'h24EC);
      chk("bp_hold_valid", out_valid, 16'd1);
      chk("bp_in_ready", in_ready, 16'd0);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 16'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_accept_busy", busy, 16'd1);
    chk("bp_consumed", out_valid, 16'd0);
    drain();

    // key_load and in_valid together: key wins, block goes next cycle with the new key.
    load_iv(16'h0000);
    key_load   = 1'b1;
    key        = 16'hA73B;
    in_valid   = 1'b1;
    in_encrypt = 1'b1;
    in_data    = 16'h6F6B;
    sb.push_back(16'h0738);
    @(negedge clk);
    chk("kl_in_ready", in_ready, 16'd0);
    tick();
    key_load = 1'b0;
    @(negedge clk);
    chk("kl_in_ready_next", in_ready, 16'd1);
    tick();
    in_valid = 1'b0;
    chk("kl_accept_busy", busy, 16'd1);
    drain();

    // Reset while in R1: block discarded, key back to 4AF5, chain back to zero.
    send(1'b1, 16'h1234, 16'h0000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("r1rst_busy", busy, 16'd0);
    chk("r1rst_out_valid", out_valid, 16'd0);
    chk("r1rst_out_data", out_data, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("r1rst_no_pulse", out_valid, 16'd0);
    end
    tick();
    send(1'b1, 16'hD728, 16'h24EC, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/saes_cbc_engine.md
Name: saes_cbc_engine

Overview:
- Sequential, handshaked Simplified-AES (16-bit block, 16-bit key) engine that computes one round per clock.
- Holds a cached key schedule and, optionally, a CBC chaining register.
- Per-block encrypt/decrypt select.
- Sits between a block source and a block sink on valid/ready streams, replacing the purely combinational single-shot cipher path.

Parameters:
- CBC_EN, 1, 1 = CBC chaining enabled; 0 = ECB only (chain register and iv ports tied off, iv_load ignored).
- RST_KEY, 16'h0000, key-register value after reset; subkeys reset to its expansion.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_load  in  1  load new key (single-cycle strobe).
- key  in  16  cipher key, sampled on an accepted key_load.
- iv_load  in  1  load chaining register (single-cycle strobe).
- iv  in  16  IV, sampled on an accepted iv_load.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept a block.
- in_encrypt  in  1  1 = encrypt, 0 = decrypt; sampled with the block.
- in_data  in  16  plaintext (encrypt) or ciphertext (decrypt).
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- out_data  out  16  result block.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state = IDLE, out_valid = 0, out_data = 0, busy = 0. Key regs = RST_KEY and its expansion (k0, k1, k2). Chain = 0.
- Key schedule: standard S-AES. w0..w5, RCON1 = 8'h80, RCON2 = 8'h30. k0 = key, k1 = {w2,w3}, k2 = {w4,w5}. All are registered on key_load.
- Key load:
  - key_load is accepted only in IDLE; it is ignored in other states.
  - If key_load and in_valid arrive in the same IDLE cycle, the key wins and in_ready = 0 that cycle.
  - The new key applies to the next accepted block.
- IV load:
  - iv_load is accepted only in IDLE with in_valid low.
  - Otherwise it is ignored.
- in_ready = (state == IDLE) && !key_load && (!out_valid || out_ready).
- States: IDLE -> R1 -> R2 -> IDLE.
- Edge E0 (handshake): capture mode, and capture the pre-chained input:
  - Encrypt: x = in_data ^ chain (CBC_EN = 1), else in_data. Register st = x ^ k0.
  - Decrypt: register st = in_data ^ k2. Save cin = in_data.
- E1 (state R1), result registered into st:
  - Encrypt: NS, SR, MC, then ^k1.
  - Decrypt: InvSR, InvNS, ^k1, then InvMC.
- E2 (state R2):
  - Encrypt: r = SR(NS(st)) ^ k2.
  - Decrypt: r = InvNS(InvSR(st)) ^ k0, then r ^= chain if CBC_EN.
  - Register out_data = r, set out_valid = 1, return to IDLE.
  - Chain update (CBC_EN only): chain <= r on encrypt, chain <= cin on decrypt.
- Latency: out_valid is high 2 cycles after the input handshake.
- Throughput: 1 block per 3 cycles when out_ready is held high. A new block may be accepted in the same cycle the previous result is consumed.
- Output hold: out_valid and out_data are stable until out_ready. out_valid falls on the edge where out_valid && out_ready, unless a new result is written on that edge (not possible given the state sequence).
- Backpressure: while out_valid && !out_ready, in_ready = 0. No result is ever dropped or overwritten.
- Reset mid-operation: the in-flight block is discarded. No out_valid pulse follows. The key and chain revert to reset values.
- Arithmetic:
  - NS uses the standard S-AES S-box and inverse S-box.
  - MC uses the matrix [1 4; 4 1] over GF(2^4), poly x^4 + x + 1.
  - InvMC uses [9 2; 2 9].
  - Nibble order is b15..b12 = n0, column-major.

Decomposition:
- Package saes_pkg:
  - sbox and inv_sbox functions.
  - gf16_mul function.
  - RCON1 and RCON2 constants.
  - State enum {IDLE, R1, R2}.
- One combinational sub-module, saes_round_datapath:
  - Inputs: st, subkey, encrypt, mix_en.
  - Output: next state.
  - Instantiated once and shared by R1 and R2.
- Key expansion is an inline function in the package, evaluated only at key load.

Test Plan:
- ECB encrypt: key_load 16'h4AF5, then in_data 16'hD728 with encrypt -> out_data 16'h24EC, out_valid 2 cycles after the handshake.
- ECB decrypt: key 16'hA73B, in_data 16'h0738 with decrypt -> 16'h6F6B. Then encrypt 16'h6F6B -> 16'h0738.
- CBC encrypt (key 16'h4AF5, iv_load 16'h0000):
  - Block 16'hD728 -> 16'h24EC.
  - Next block 16'hF3C4 -> 16'h24EC (chain XOR yields D728).
  - Then decrypt with iv 0: 16'h24EC, 16'h24EC -> 16'hD728, 16'hF3C4.
- Backpressure: out_ready held 0 for 5 cycles after result 16'h24EC. out_data stays 16'h24EC, in_ready = 0, and a pending in_valid is not accepted until the out_ready cycle.
- Simultaneous key_load and in_valid in IDLE: in_ready = 0 and the key is loaded. The block is accepted next cycle and uses the new key (key 16'hA73B, 16'h6F6B -> 16'h0738).
- Reset in R1:
  - rst asserted in R1 -> out_valid stays 0, busy = 0 next cycle.
  - Key reverts to RST_KEY; chain = 0.
  - Next block is processed correctly.
